// File: rtl/i2c_resp_pkg.sv
// i2c_resp_pkg: FSM state type and bus constants shared by the I2C responder.
package i2c_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_resp_state_t;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sig_filter.sv
// i2c_sig_filter: 2-flop synchronizer plus FILT_LEN glitch filter with registered edge flags.
module i2c_sig_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is accepted only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                lvl_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = !sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_resp_slave.sv
// i2c_resp_slave: I2C target with a byte register file reached by the pointer-then-data protocol,
// plus a host read port and write strobe for scoreboarding.
module i2c_resp_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         NUM_REGS   = 16,
    parameter int         FILT_LEN   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        scl_o,
    output logic                        sda_o,
    output logic                        busy_o,
    output logic                        wr_stb_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
    output logic [7:0]                  wr_data_o,
    input  logic [$clog2(NUM_REGS)-1:0] hst_addr_i,
    output logic [7:0]                  hst_data_o
);

    import i2c_resp_pkg::*;

    localparam int AW = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_resp_state_t state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            rw_q, rw_d;
    logic            first_q, first_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic            sda_q, sda_d;
    logic            busy_q, busy_d;
    logic            wr_stb_q, wr_stb_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      hst_data_q, hst_data_d;
    logic [7:0]      rx_byte;
    logic            last_bit;

    i2c_sig_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (scl_i),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sig_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (sda_i),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start    = sda_fall && scl_lvl;
    assign stop     = sda_rise && scl_lvl;
    assign rx_byte  = {shift_q[6:0], sda_lvl};
    assign last_bit = bit_cnt_q == 3'd7;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        first_d    = first_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        hst_data_d = regs_q[hst_addr_i];
        if (stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            sda_d   = 1'b1;
        end else if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b1;
            sda_d     = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        rw_d    = rx_byte[0];
                        state_d = rx_byte[7:1] == SLAVE_ADDR ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                // First fall pulls SDA low for the ACK slot, the second ends it.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (sda_q) begin
                        sda_d = I2C_ACK;
                    end else begin
                        sda_d     = 1'b1;
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_WR_ACK || rw_q == I2C_RW_WRITE) begin
                            state_d = ST_WR_BYTE;
                            first_d = state_q == ST_ADDR_ACK;
                        end else begin
                            state_d = ST_RD_BYTE;
                            sda_d   = regs_q[ptr_q][7];
                            shift_d = {regs_q[ptr_q][6:0], 1'b1};
                        end
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = ST_WR_ACK;
                        if (first_q) begin
                            ptr_d   = rx_byte[AW-1:0];
                            first_d = 1'b0;
                        end else begin
                            regs_d[ptr_q] = rx_byte;
                            wr_stb_d      = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = rx_byte;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end
                end
                // SDA stays on the last bit until SCL falls so no STOP is faked.
                ST_RD_BYTE: if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = ST_RD_ACK;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end else if (scl_fall) begin
                    sda_d   = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b1};
                end
                ST_RD_ACK: if (scl_fall) begin
                    sda_d = 1'b1;
                end else if (scl_rise) begin
                    bit_cnt_d = 3'd0;
                    shift_d   = regs_q[ptr_q];
                    state_d   = sda_lvl == I2C_ACK ? ST_RD_BYTE : ST_IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= I2C_RW_WRITE;
            first_q    <= 1'b0;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            hst_data_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hst_data_q <= hst_data_d;
            regs_q     <= regs_d;
        end
    end

    assign scl_o      = 1'b1;
    assign sda_o      = sda_q;
    assign busy_o     = busy_q;
    assign wr_stb_o   = wr_stb_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign hst_data_o = hst_data_q;

endmodule

// File: tb/tb_i2c_resp_slave.sv
// tb_i2c_resp_slave: bit-banged I2C master with a write-strobe scoreboard and a register model.
module tb_i2c_resp_slave;

    localparam int Q = 20;
    localparam int H = 40;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] hst_addr_i = 4'h0;
    logic       scl_o, sda_o, busy_o, wr_stb_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o, hst_data_o;
    logic       sda_bus;

    assign sda_bus = m_sda & sda_o;

    i2c_resp_slave dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .scl_i      (m_scl),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .busy_o     (busy_o),
        .wr_stb_o   (wr_stb_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .hst_addr_i (hst_addr_i),
        .hst_data_o (hst_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] ptr;
        int         n;
        logic [7:0] d [3];
    } vec_t;

    vec_t        tbl [4];
    logic [7:0]  mdl [16];
    logic [3:0]  mptr;
    logic [11:0] exp_q [$];
    logic [7:0]  exp_rd [$];
    logic [11:0] obs [64];
    int          obs_n = 0;
    int          rd_idx = 0;
    int          low_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Strobe log and SDA-drive counter, written only here.
    always @(negedge clk) begin
        if (wr_stb_o && obs_n < 64) begin
            obs[obs_n] <= {wr_addr_o, wr_data_o};
            obs_n      <= obs_n + 1;
        end
        if (!sda_o) low_cnt <= low_cnt + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        hold(Q); m_sda = 1'b1;
        hold(Q); m_scl = 1'b1;
        hold(H); m_sda = 1'b0;
        hold(H); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        hold(Q); m_sda = 1'b0;
        hold(Q); m_scl = 1'b1;
        hold(H); m_sda = 1'b1;
        hold(H);
    endtask

    // g: 1 = 2-clock SCL low glitch while high, 2 = 2-clock SDA dip while high.
    task automatic wbit(input logic b, input int g);
        hold(Q); m_sda = b;
        hold(Q); m_scl = 1'b1;
        hold(Q);
        if (g == 1) begin m_scl = 1'b0; hold(2); m_scl = 1'b1; end
        if (g == 2) begin m_sda = 1'b0; hold(2); m_sda = b; end
        hold(Q); m_scl = 1'b0;
    endtask

    task automatic rbit(output logic b);
        hold(Q); m_sda = 1'b1;
        hold(Q); m_scl = 1'b1;
        hold(Q); b = sda_bus;
        hold(Q); m_scl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, input int gs, input int gd, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i], i == gs ? 1 : (i == gd ? 2 : 0));
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) rbit(d[i]);
        wbit(ack, 0);
    endtask

    task automatic host_chk(input logic [3:0] a);
        hst_addr_i = a;
        hold(1);
        chk("host_rd", 16'(hst_data_o), 16'(mdl[a]));
    endtask

    task automatic drain();
        logic [11:0] e;
        while (rd_idx < obs_n) begin
            e = exp_q.size() != 0 ? exp_q.pop_front() : 12'hFFF;
            chk("wr_stb", 16'(obs[rd_idx]), 16'(e));
            rd_idx++;
        end
        chk("wr_pending", 16'(exp_q.size()), 16'h0);
        exp_q.delete();
    endtask

    task automatic do_read(input logic [3:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        logic [3:0] idx;
        i2c_start();
        wbyte(8'h44, -1, -1, ack); chk("rd_adrw_ack", 16'(ack), 16'h0);
        wbyte({4'h0, p}, -1, -1, ack); chk("rd_ptr_ack", 16'(ack), 16'h0);
        i2c_start();
        wbyte(8'h45, -1, -1, ack); chk("rd_adrr_ack", 16'(ack), 16'h0);
        idx = p;
        for (int k = 0; k < n; k++) begin exp_rd.push_back(mdl[idx]); idx++; end
        for (int k = 0; k < n; k++) begin
            rbyte(d, k == n - 1);
            chk("rd_data", 16'(d), 16'(exp_rd.pop_front()));
        end
        i2c_stop(); hold(10);
        chk("rd_busy_stop", 16'(busy_o), 16'h0);
        drain();
    endtask

    initial begin
        logic       ack, hit, b;
        int         lc;
        tbl[0] = '{8'h44, 8'h03, 2, '{8'hA5, 8'h5A, 8'h00}};
        tbl[1] = '{8'h46, 8'h11, 0, '{8'h00, 8'h00, 8'h00}};
        tbl[2] = '{8'h44, 8'h0F, 3, '{8'h01, 8'h02, 8'h03}};
        tbl[3] = '{8'h44, 8'h27, 1, '{8'hC3, 8'h00, 8'h00}};
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mptr = 4'h0;
        hold(5);
        chk("rst_sda", 16'(sda_o), 16'h1);
        chk("rst_scl", 16'(scl_o), 16'h1);
        chk("rst_busy", 16'(busy_o), 16'h0);
        chk("rst_stb", 16'(wr_stb_o), 16'h0);
        chk("rst_waddr", 16'(wr_addr_o), 16'h0);
        chk("rst_wdata", 16'(wr_data_o), 16'h0);
        chk("rst_hdata", 16'(hst_data_o), 16'h0);
        rst_i = 1'b0;
        hold(10);

        for (int v = 0; v < 4; v++) begin
            hit = tbl[v].adr[7:1] == 7'h22;
            lc  = low_cnt;
            i2c_start();
            chk("busy_start", 16'(busy_o), 16'h1);
            wbyte(tbl[v].adr, -1, -1, ack); chk("addr_ack", 16'(ack), hit ? 16'h0 : 16'h1);
            wbyte(tbl[v].ptr, -1, -1, ack); chk("ptr_ack", 16'(ack), hit ? 16'h0 : 16'h1);
            if (hit) mptr = tbl[v].ptr[3:0];
            for (int k = 0; k < tbl[v].n; k++) begin
                wbyte(tbl[v].d[k], -1, -1, ack); chk("data_ack", 16'(ack), hit ? 16'h0 : 16'h1);
                if (hit) begin
                    exp_q.push_back({mptr, tbl[v].d[k]});
                    mdl[mptr] = tbl[v].d[k];
                    mptr++;
                end
            end
            i2c_stop(); hold(10);
            chk("busy_stop", 16'(busy_o), 16'h0);
            if (!hit) chk("ignore_no_drive", 16'(low_cnt - lc), 16'h0);
            drain();
            for (int a = 0; a < 16; a++) host_chk(4'(a));
        end

        do_read(4'h3, 2);
        do_read(4'hF, 3);

        // Glitches: SDA dip on bit 7 and SCL low pulse on bit 3 of the data byte.
        i2c_start();
        wbyte(8'h44, -1, -1, ack); chk("gl_addr_ack", 16'(ack), 16'h0);
        wbyte(8'h08, -1, -1, ack); chk("gl_ptr_ack", 16'(ack), 16'h0);
        exp_q.push_back({4'h8, 8'h96});
        mdl[8] = 8'h96;
        wbyte(8'h96, 3, 7, ack); chk("gl_data_ack", 16'(ack), 16'h0);
        chk("gl_busy", 16'(busy_o), 16'h1);
        i2c_stop(); hold(10);
        drain();
        host_chk(4'h8);

        // Reset while the target drives a 0 data bit (bit 6 of 0xA5).
        i2c_start();
        wbyte(8'h44, -1, -1, ack); chk("rs_addr_ack", 16'(ack), 16'h0);
        wbyte(8'h03, -1, -1, ack); chk("rs_ptr_ack", 16'(ack), 16'h0);
        i2c_start();
        wbyte(8'h45, -1, -1, ack); chk("rs_rd_ack", 16'(ack), 16'h0);
        rbit(b); chk("rs_bit7", 16'(b), 16'h1);
        hold(Q);
        chk("rs_pre_sda", 16'(sda_o), 16'h0);
        rst_i = 1'b1;
        #1;
        chk("rs_async_sda", 16'(sda_o), 16'h1);
        hold(3);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        hold(10);
        chk("rs_busy", 16'(busy_o), 16'h0);
        i2c_stop(); hold(10);
        chk("rs_busy_stop", 16'(busy_o), 16'h0);
        for (int a = 0; a < 16; a++) host_chk(4'(a));

        i2c_start();
        wbyte(8'h44, -1, -1, ack); chk("post_addr_ack", 16'(ack), 16'h0);
        wbyte(8'h02, -1, -1, ack); chk("post_ptr_ack", 16'(ack), 16'h0);
        exp_q.push_back({4'h2, 8'h77});
        mdl[2] = 8'h77;
        wbyte(8'h77, -1, -1, ack); chk("post_data_ack", 16'(ack), 16'h0);
        i2c_stop(); hold(10);
        drain();
        host_chk(4'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
